// File: rtl/lfsr_challenge_gen.sv
// Parametrised Fibonacci-LFSR challenge generator for the serial PUF datapath.
// Emits a burst of challenges under valid/ready and flags all-zero lock-up.
module lfsr_challenge_gen #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH-1:0]   seed_i,
  input  logic [WIDTH-1:0]   taps_i,
  input  logic [COUNT_W-1:0] num_challenges_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic [WIDTH-1:0]   out_challenge_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               lockup_o,
  output logic [COUNT_W-1:0] challenges_sent_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   taps_q, taps_d;
  logic [COUNT_W-1:0] num_q, num_d;
  logic [COUNT_W-1:0] sent_q, sent_d;
  logic               lockup_q, lockup_d;

  logic [WIDTH-1:0]   lfsr_next;
  logic [COUNT_W-1:0] sent_inc;
  logic               handshake;

  assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & taps_q)};
  assign sent_inc  = sent_q + COUNT_W'(1);
  assign handshake = (state_q == RUN) && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q   <= '0;
      taps_q   <= '0;
      num_q    <= '0;
      sent_q   <= '0;
      lockup_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      taps_q   <= taps_d;
      num_q    <= num_d;
      sent_q   <= sent_d;
      lockup_q <= lockup_d;
    end
  end

  // A handshake always completes first, so it beats a coincident abort.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    taps_d   = taps_q;
    num_d    = num_q;
    sent_d   = sent_q;
    lockup_d = lockup_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          lfsr_d   = seed_i;
          taps_d   = taps_i;
          num_d    = num_challenges_i;
          sent_d   = '0;
          lockup_d = (seed_i == '0);
          if (seed_i == '0 || num_challenges_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (handshake) begin
          lfsr_d = lfsr_next;
          sent_d = sent_inc;
          if (lfsr_next == '0) begin
            lockup_d = 1'b1;
          end
          if (sent_inc == num_q || lfsr_next == '0) begin
            state_d = DONE;
          end else if (abort_i) begin
            state_d = IDLE;
          end
        end else if (abort_i) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      RUN: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign out_challenge_o   = lfsr_q;
  assign lockup_o          = lockup_q;
  assign challenges_sent_o = sent_q;

endmodule

// File: tb/tb_lfsr_challenge_gen.sv
// Directed bench for lfsr_challenge_gen: an 8-bit instance for the main
// scenarios and a 4-bit instance for the maximal-period sequence.
module tb_lfsr_challenge_gen;

  logic        clk;
  logic        rst_n;

  logic [7:0]  seed, taps;
  logic [15:0] num;
  logic        start, abort, ready;
  logic [7:0]  ch;
  logic        valid, busy, done, lockup;
  logic [15:0] sent;

  logic [3:0]  seed4, taps4;
  logic [15:0] num4;
  logic        start4, abort4, ready4;
  logic [3:0]  ch4;
  logic        valid4, busy4, done4, lockup4;
  logic [15:0] sent4;

  int total = 0;
  int bad   = 0;

  lfsr_challenge_gen #(.WIDTH(8), .COUNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .seed_i(seed), .taps_i(taps),
    .num_challenges_i(num), .start_i(start), .abort_i(abort),
    .out_challenge_o(ch), .out_valid_o(valid), .out_ready_i(ready),
    .busy_o(busy), .done_o(done), .lockup_o(lockup), .challenges_sent_o(sent)
  );

  lfsr_challenge_gen #(.WIDTH(4), .COUNT_W(16)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .seed_i(seed4), .taps_i(taps4),
    .num_challenges_i(num4), .start_i(start4), .abort_i(abort4),
    .out_challenge_o(ch4), .out_valid_o(valid4), .out_ready_i(ready4),
    .busy_o(busy4), .done_o(done4), .lockup_o(lockup4), .challenges_sent_o(sent4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] t, input logic [15:0] n);
    seed  = s;
    taps  = t;
    num   = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [7:0] exp8 [5] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16};
  logic [3:0] exp4 [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

  initial begin
    logic [3:0] pat;
    int idx;
    int cyc;

    rst_n = 1'b0;
    seed = '0; taps = '0; num = '0; start = 0; abort = 0; ready = 0;
    seed4 = '0; taps4 = '0; num4 = '0; start4 = 0; abort4 = 0; ready4 = 0;
    #3;
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_lockup", lockup, 0);
    checkOutput("rst_sent", sent, 0);
    checkOutput("rst_ch", ch, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] basic sequence");
    ready = 1'b1;
    applyStimulus(8'h01, 8'h8E, 16'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("seq_valid%0d", i), valid, 1);
      checkOutput($sformatf("seq_ch%0d", i), ch, exp8[i]);
      step();
    end
    checkOutput("seq_valid_end", valid, 0);
    checkOutput("seq_done", done, 1);
    checkOutput("seq_busy_done", busy, 1);
    checkOutput("seq_sent", sent, 5);
    checkOutput("seq_lockup", lockup, 0);
    step();
    checkOutput("seq_done_pulse", done, 0);
    checkOutput("seq_busy_idle", busy, 0);

    $display("[TB] backpressure");
    pat = 4'b1001;
    ready = 1'b0;
    applyStimulus(8'h01, 8'h8E, 16'd5);
    idx = 0;
    cyc = 0;
    while (idx < 5 && cyc < 40) begin
      ready = pat[cyc % 4];
      checkOutput($sformatf("bp_valid_c%0d", cyc), valid, 1);
      checkOutput($sformatf("bp_ch_c%0d", cyc), ch, exp8[idx]);
      if (ready) idx++;
      step();
      cyc++;
    end
    if (idx != 5) checkOutput("bp_timeout", idx, 5);
    ready = 1'b1;
    checkOutput("bp_done", done, 1);
    checkOutput("bp_sent", sent, 5);
    step();

    $display("[TB] lock-up");
    applyStimulus(8'h80, 8'h00, 16'd10);
    checkOutput("lk_valid", valid, 1);
    checkOutput("lk_ch", ch, 8'h80);
    step();
    checkOutput("lk_done", done, 1);
    checkOutput("lk_lockup", lockup, 1);
    checkOutput("lk_sent", sent, 1);
    checkOutput("lk_valid_off", valid, 0);
    step();
    checkOutput("lk_sticky", lockup, 1);
    checkOutput("lk_idle", busy, 0);

    applyStimulus(8'h00, 8'h8E, 16'd5);
    checkOutput("zs_done", done, 1);
    checkOutput("zs_lockup", lockup, 1);
    checkOutput("zs_valid", valid, 0);
    step();

    $display("[TB] zero count");
    applyStimulus(8'h01, 8'h8E, 16'd0);
    checkOutput("zc_done", done, 1);
    checkOutput("zc_valid", valid, 0);
    checkOutput("zc_lockup_clr", lockup, 0);
    step();
    checkOutput("zc_idle", busy, 0);

    $display("[TB] abort");
    applyStimulus(8'h01, 8'h8E, 16'd100);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("ab_ch%0d", i), ch, exp8[i]);
      step();
    end
    ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("ab_valid", valid, 0);
    checkOutput("ab_busy", busy, 0);
    checkOutput("ab_done", done, 0);
    checkOutput("ab_sent", sent, 3);
    step();
    checkOutput("ab_nodone", done, 0);
    applyStimulus(8'h01, 8'h8E, 16'd5);
    checkOutput("ab_restart_valid", valid, 1);
    checkOutput("ab_restart_ch", ch, 8'h01);
    checkOutput("ab_restart_sent", sent, 0);

    $display("[TB] reset mid-burst");
    ready = 1'b1;
    step();
    checkOutput("mr_ch_before", ch, 8'h02);
    rst_n = 1'b0;
    #2;
    checkOutput("mr_valid", valid, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_ch", ch, 0);
    checkOutput("mr_sent", sent, 0);
    checkOutput("mr_done", done, 0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("mr_idle_busy", busy, 0);
    checkOutput("mr_idle_done", done, 0);
    applyStimulus(8'h01, 8'h8E, 16'd1);
    checkOutput("mr_restart_ch", ch, 8'h01);
    step();
    checkOutput("mr_restart_done", done, 1);
    step();

    $display("[TB] 4-bit maximal period");
    seed4 = 4'h1; taps4 = 4'hC; num4 = 16'd16; ready4 = 1'b1; start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("w4_ch%0d", i), ch4, exp4[i]);
      step();
    end
    checkOutput("w4_done", done4, 1);
    checkOutput("w4_sent", sent4, 16);
    checkOutput("w4_lockup", lockup4, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
